// File: rtl/mips_multicycle_ctrl_pkg.sv
// rtl/mips_multicycle_ctrl_pkg.sv - state codes, opcode constants and select encodings for the multicycle control
package mips_multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_R_WB, S_EXEC_I, S_I_WB, S_MEM_ADDR, S_MEM_RD,
    S_MEM_WB, S_MEM_WR, S_BRANCH, S_JUMP, S_JR, S_LUI_WB, S_HALT, S_ERROR
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_HALT  = 6'b111111;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [1:0] DST_RT = 2'b00, DST_RD = 2'b01, DST_RA = 2'b10;
  localparam logic [1:0] WB_ALUOUT = 2'b00, WB_MDR = 2'b01, WB_PC = 2'b10, WB_LUI = 2'b11;
  localparam logic [1:0] SRCB_RT = 2'b00, SRCB_FOUR = 2'b01, SRCB_EXT = 2'b10, SRCB_EXT_SH = 2'b11;
  localparam logic [1:0] ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_FUNCT = 2'b10, ALU_IMM = 2'b11;
  localparam logic [1:0] PC_ALU = 2'b00, PC_ALUOUT = 2'b01, PC_JUMP = 2'b10, PC_RS = 2'b11;

  // Unknown opcodes map to S_FETCH; the caller treats that as the illegal case.
  function automatic state_t decode_target(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      OP_RTYPE:                          return (fn == FN_JR) ? S_JR : S_EXEC_R;
      OP_LW, OP_SW:                      return S_MEM_ADDR;
      OP_BEQ, OP_BNE:                    return S_BRANCH;
      OP_J, OP_JAL:                      return S_JUMP;
      OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: return S_EXEC_I;
      OP_LUI:                            return S_LUI_WB;
      OP_HALT:                           return S_HALT;
      default:                           return S_FETCH;
    endcase
  endfunction

  function automatic logic [1:0] imm_op_of(input logic [5:0] op);
    case (op)
      OP_ANDI: return 2'b01;
      OP_ORI:  return 2'b10;
      OP_SLTI: return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_mem_wait_timer.sv
// rtl/mips_multicycle_ctrl_mem_wait_timer.sv - memory wait counter with clear/inc and expiry flag
module mem_wait_timer #(
  parameter int LIMIT = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [W-1:0] cnt;

  assign expired = (cnt == W'(LIMIT - 1));

  always_ff @(posedge clock) begin
    if (!reset || clear) cnt <= '0;
    else if (inc && !expired) cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - multicycle MIPS control FSM with memory handshake, timeout, halt and retire counter
module mips_multicycle_ctrl
  import mips_multicycle_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero_flag,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             ir_en,
  output logic             mem_read,
  output logic             mem_write,
  output logic             iord,
  output logic             reg_write,
  output logic [1:0]       reg_dst,
  output logic [1:0]       wb_sel,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       imm_op,
  output logic             ext_op,
  output logic [1:0]       pc_src,
  output logic             illegal_op,
  output logic             bus_error,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count
);

  state_t state;
  logic   in_wait, expired;

  assign in_wait = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);

  // Leaving a wait state always coincides with !in_wait or mem_ready, so both clear the count.
  mem_wait_timer #(.LIMIT(MEM_TIMEOUT)) u_timer (
    .clock   (clock),
    .reset   (reset),
    .clear   (!in_wait || mem_ready),
    .inc     (in_wait && !mem_ready),
    .expired (expired)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= S_FETCH;
      bus_error   <= 1'b0;
      instr_count <= '0;
    end else begin
      case (state)
        S_FETCH, S_MEM_RD: begin
          if (mem_ready) state <= (state == S_FETCH) ? S_DECODE : S_MEM_WB;
          else if (expired) begin
            state     <= S_ERROR;
            bus_error <= 1'b1;
          end
        end
        S_MEM_WR: begin
          if (mem_ready) begin
            state       <= S_FETCH;
            instr_count <= instr_count + CNT_W'(1);
          end else if (expired) begin
            state     <= S_ERROR;
            bus_error <= 1'b1;
          end
        end
        S_DECODE:   state <= decode_target(opcode, funct);
        S_EXEC_R:   state <= S_R_WB;
        S_EXEC_I:   state <= S_I_WB;
        S_MEM_ADDR: state <= (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
        S_R_WB, S_I_WB, S_MEM_WB, S_BRANCH, S_JUMP, S_JR, S_LUI_WB: begin
          state       <= S_FETCH;
          instr_count <= instr_count + CNT_W'(1);
        end
        default:    state <= state;
      endcase
    end
  end

  always_comb begin
    pc_en      = 1'b0;
    ir_en      = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = DST_RT;
    wb_sel     = WB_ALUOUT;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_FOUR;
    alu_op     = ALU_ADD;
    imm_op     = imm_op_of(opcode);
    ext_op     = !((opcode == OP_ANDI) || (opcode == OP_ORI));
    pc_src     = PC_ALU;
    illegal_op = 1'b0;
    halted     = 1'b0;
    case (state)
      S_FETCH: begin
        mem_read = 1'b1;
        ir_en    = mem_ready;
        pc_en    = mem_ready;
      end
      S_DECODE: begin
        alu_src_b  = SRCB_EXT_SH;
        illegal_op = (decode_target(opcode, funct) == S_FETCH);
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_RT;
        alu_op    = ALU_FUNCT;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_EXT;
        alu_op    = ALU_IMM;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_EXT;
        iord      = 1'b1;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        ir_en    = mem_ready;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = DST_RD;
      end
      S_I_WB:   reg_write = 1'b1;
      S_MEM_WB: begin
        reg_write = 1'b1;
        wb_sel    = WB_MDR;
      end
      S_LUI_WB: begin
        reg_write = 1'b1;
        wb_sel    = WB_LUI;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_RT;
        alu_op    = ALU_SUB;
        pc_src    = PC_ALUOUT;
        pc_en     = ((opcode == OP_BEQ) && zero_flag) || ((opcode == OP_BNE) && !zero_flag);
      end
      S_JUMP: begin
        pc_en  = 1'b1;
        pc_src = PC_JUMP;
        if (opcode == OP_JAL) begin
          reg_write = 1'b1;
          reg_dst   = DST_RA;
          wb_sel    = WB_PC;
        end
      end
      S_JR: begin
        pc_en  = 1'b1;
        pc_src = PC_RS;
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
    if (!reset) begin
      pc_en     = 1'b0;
      ir_en     = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
    end
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb/tb_mips_multicycle_ctrl.sv - directed self-checking bench for the multicycle control FSM
module tb_mips_multicycle_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic [5:0]  opcode, funct;
  logic        zero_flag, mem_ready;
  logic        pc_en, ir_en, mem_read, mem_write, iord, reg_write;
  logic [1:0]  reg_dst, wb_sel, alu_src_b, alu_op, imm_op, pc_src;
  logic        alu_src_a, ext_op, illegal_op, bus_error, halted;
  logic [31:0] instr_count;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  mips_multicycle_ctrl #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
    .clock(clock), .reset(reset), .opcode(opcode), .funct(funct),
    .zero_flag(zero_flag), .mem_ready(mem_ready), .pc_en(pc_en), .ir_en(ir_en),
    .mem_read(mem_read), .mem_write(mem_write), .iord(iord), .reg_write(reg_write),
    .reg_dst(reg_dst), .wb_sel(wb_sel), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .imm_op(imm_op), .ext_op(ext_op), .pc_src(pc_src),
    .illegal_op(illegal_op), .bus_error(bus_error), .halted(halted),
    .instr_count(instr_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change at posedge+2, outputs are sampled at posedge+3.
  task automatic nxt();
    @(posedge clock);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; opcode = 6'b000000; funct = 6'b100000; zero_flag = 1'b0; mem_ready = 1'b1;
    repeat (2) @(posedge clock);
    #3;
    check("rst_pc_en", 32'(pc_en), 0);
    check("rst_ir_en", 32'(ir_en), 0);
    check("rst_mem_read", 32'(mem_read), 0);
    check("rst_count", instr_count, 0);
    check("rst_bus_error", 32'(bus_error), 0);

    // add: FETCH, DECODE, EXEC_R, R_WB
    reset = 1'b1; #1;
    check("add_f_mem_read", 32'(mem_read), 1);
    check("add_f_ir_en", 32'(ir_en), 1);
    check("add_f_pc_en", 32'(pc_en), 1);
    check("add_f_src_b", 32'(alu_src_b), 1);
    nxt(); #1;
    check("add_d_src_b", 32'(alu_src_b), 3);
    check("add_d_illegal", 32'(illegal_op), 0);
    check("add_d_mem_read", 32'(mem_read), 0);
    nxt(); #1;
    check("add_x_src_a", 32'(alu_src_a), 1);
    check("add_x_alu_op", 32'(alu_op), 2);
    nxt(); #1;
    check("add_wb_reg_write", 32'(reg_write), 1);
    check("add_wb_reg_dst", 32'(reg_dst), 1);
    check("add_wb_count", instr_count, 0);
    nxt(); #1;
    check("add_count", instr_count, 1);

    // lw with three wait cycles in MEM_RD: 8 cycles total
    opcode = 6'b100011; #1;
    check("lw_f_ir_en", 32'(ir_en), 1);
    nxt(); #1;
    check("lw_d_ir_en", 32'(ir_en), 0);
    nxt(); #1;
    check("lw_addr_src_b", 32'(alu_src_b), 2);
    for (int i = 0; i < 3; i++) begin
      nxt(); mem_ready = 1'b0; #1;
      check("lw_rd_wait_mem_read", 32'(mem_read), 1);
      check("lw_rd_wait_iord", 32'(iord), 1);
      check("lw_rd_wait_ir_en", 32'(ir_en), 0);
    end
    nxt(); mem_ready = 1'b1; #1;
    check("lw_rd_mdr_latch", 32'(ir_en), 1);
    nxt(); #1;
    check("lw_wb_sel", 32'(wb_sel), 1);
    check("lw_wb_reg_write", 32'(reg_write), 1);
    check("lw_wb_reg_dst", 32'(reg_dst), 0);
    nxt(); #1;
    check("lw_next_fetch_iord", 32'(iord), 0);
    check("lw_next_fetch_read", 32'(mem_read), 1);
    check("lw_count", instr_count, 2);

    // beq taken
    opcode = 6'b000100; zero_flag = 1'b1;
    nxt(); nxt(); #1;
    check("beq_pc_en", 32'(pc_en), 1);
    check("beq_pc_src", 32'(pc_src), 1);
    check("beq_alu_op", 32'(alu_op), 1);
    nxt(); #1;
    check("beq_count", instr_count, 3);

    // bne with zero set: not taken
    opcode = 6'b000101;
    nxt(); nxt(); #1;
    check("bne_pc_en", 32'(pc_en), 0);
    nxt(); #1;
    check("bne_count", instr_count, 4);

    // andi
    opcode = 6'b001100; zero_flag = 1'b0;
    nxt(); nxt(); #1;
    check("andi_alu_op", 32'(alu_op), 3);
    check("andi_imm_op", 32'(imm_op), 1);
    check("andi_ext_op", 32'(ext_op), 0);
    check("andi_src_b", 32'(alu_src_b), 2);
    nxt(); #1;
    check("andi_wb_reg_write", 32'(reg_write), 1);
    check("andi_wb_reg_dst", 32'(reg_dst), 0);
    nxt(); #1;
    check("andi_count", instr_count, 5);

    // jal
    opcode = 6'b000011;
    nxt(); nxt(); #1;
    check("jal_pc_en", 32'(pc_en), 1);
    check("jal_pc_src", 32'(pc_src), 2);
    check("jal_reg_write", 32'(reg_write), 1);
    check("jal_reg_dst", 32'(reg_dst), 2);
    check("jal_wb_sel", 32'(wb_sel), 2);
    nxt(); #1;
    check("jal_count", instr_count, 6);

    // sw with one wait cycle
    opcode = 6'b101011;
    nxt(); nxt(); nxt(); mem_ready = 1'b0; #1;
    check("sw_wait_mem_write", 32'(mem_write), 1);
    check("sw_wait_iord", 32'(iord), 1);
    check("sw_wait_reg_write", 32'(reg_write), 0);
    nxt(); mem_ready = 1'b1; #1;
    check("sw_done_mem_write", 32'(mem_write), 1);
    nxt(); #1;
    check("sw_count", instr_count, 7);

    // lui
    opcode = 6'b001111;
    nxt(); nxt(); #1;
    check("lui_wb_sel", 32'(wb_sel), 3);
    check("lui_reg_write", 32'(reg_write), 1);
    nxt(); #1;
    check("lui_count", instr_count, 8);

    // illegal opcode
    opcode = 6'b010101;
    nxt(); #1;
    check("ill_pulse", 32'(illegal_op), 1);
    check("ill_reg_write", 32'(reg_write), 0);
    nxt(); #1;
    check("ill_pulse_end", 32'(illegal_op), 0);
    check("ill_back_fetch", 32'(mem_read), 1);
    check("ill_count", instr_count, 8);

    // jr
    opcode = 6'b000000; funct = 6'b001000;
    nxt(); nxt(); #1;
    check("jr_pc_en", 32'(pc_en), 1);
    check("jr_pc_src", 32'(pc_src), 3);
    check("jr_reg_write", 32'(reg_write), 0);
    nxt(); #1;
    check("jr_count", instr_count, 9);

    // FETCH timeout with limit 4
    mem_ready = 1'b0; #1;
    check("to_fetch1_read", 32'(mem_read), 1);
    nxt(); nxt(); nxt(); #1;
    check("to_fetch4_read", 32'(mem_read), 1);
    check("to_fetch4_bus_error", 32'(bus_error), 0);
    nxt(); #1;
    check("to_err_read", 32'(mem_read), 0);
    check("to_err_bus_error", 32'(bus_error), 1);
    mem_ready = 1'b1;
    nxt(); nxt(); nxt(); #1;
    check("to_err_held", 32'(bus_error), 1);
    check("to_err_ir_en", 32'(ir_en), 0);
    check("to_err_pc_en", 32'(pc_en), 0);
    check("to_err_count", instr_count, 9);

    reset = 1'b0;
    nxt(); #1;
    check("to_rst_bus_error", 32'(bus_error), 0);
    check("to_rst_count", instr_count, 0);

    // halt is absorbing
    reset = 1'b1; opcode = 6'b111111;
    nxt(); nxt(); #1;
    check("halt_entry", 32'(halted), 1);
    for (int i = 0; i < 4; i++) begin
      nxt(); mem_ready = i[0]; #1;
    end
    check("halt_held", 32'(halted), 1);
    check("halt_pc_en", 32'(pc_en), 0);
    check("halt_mem_read", 32'(mem_read), 0);
    check("halt_count", instr_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
